// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Holds source/state encodings, widths and the aux FIFO entry layout.
package wb_port_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    SRC_PIPE = 1'b0,
    SRC_AUX  = 1'b1
  } src_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STEAL = 2'd2
  } state_e;

  typedef struct packed {
    logic              squash;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the pipeline/aux requesters and the write-port arbiter.
// Defining WB_ARB_STATS_EN adds the steal/squash statistics outputs.
interface wb_port_arbiter_if;
  import wb_port_arbiter_pkg::*;

  logic              pipe_wr_en;
  logic [REG_W-1:0]  pipe_rd;
  logic [DATA_W-1:0] pipe_data;
  logic              aux_valid;
  logic              aux_ready;
  logic [REG_W-1:0]  aux_rd;
  logic [DATA_W-1:0] aux_data;
  logic              pipe_stall;
  logic              rf_we;
  logic [REG_W-1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_src;
`ifdef WB_ARB_STATS_EN
  logic [15:0]       stat_steals;
  logic [15:0]       stat_squashes;
`endif

  modport master (
    output pipe_wr_en, pipe_rd, pipe_data, aux_valid, aux_rd, aux_data,
    input  aux_ready, pipe_stall, rf_we, rf_waddr, rf_wdata, rf_src
`ifdef WB_ARB_STATS_EN
    , input stat_steals, stat_squashes
`endif
  );

  modport slave (
    input  pipe_wr_en, pipe_rd, pipe_data, aux_valid, aux_rd, aux_data,
    output aux_ready, pipe_stall, rf_we, rf_waddr, rf_wdata, rf_src
`ifdef WB_ARB_STATS_EN
    , output stat_steals, stat_squashes
`endif
  );

endinterface

// File: rtl/wb_aux_fifo.sv
// Aux result buffer: DEPTH entries of {squash, rd, data} with a broadcast
// squash-by-rd compare so younger pipeline writes can cancel buffered results.
module wb_aux_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [REG_W-1:0]  push_rd,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              squash_en,
  input  logic [REG_W-1:0]  squash_rd,
  output fifo_entry_t       head,
  output logic              empty,
  output logic              full,
  output logic              empty_nxt,
  output logic [CNT_W-1:0]  squash_cnt
);

  fifo_entry_t      mem_q [DEPTH];
  fifo_entry_t      mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] live;

  // A slot holds a real entry when its distance from the read pointer is below the count.
  always_comb begin
    live = '0;
    for (int i = 0; i < DEPTH; i++) begin
      live[i] = CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr_q)) < count_q;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    squash_cnt = '0;

    if (squash_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (live[i] && mem_q[i].rd == squash_rd) begin
          if (!mem_q[i].squash) squash_cnt = squash_cnt + CNT_W'(1);
          mem_d[i].squash = 1'b1;
        end
      end
    end

    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (push) begin
      mem_d[wr_ptr_q] = {1'b0, push_rd, push_data};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; validity comes from the reset count and
  // pointers, and a push always rewrites the squash bit.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head      = mem_q[rd_ptr_q];
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty_nxt = (count_d == '0);

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline has priority, aux results drain
// into idle slots, starvation forces a one-cycle steal. Option: WB_ARB_STATS_EN.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input logic               clk,
  input logic               rst,
  wb_port_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_e            state_q, state_d;
  logic [7:0]        starve_q, starve_d;
  logic              rf_we_q, rf_we_d;
  logic [REG_W-1:0]  rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  src_e              rf_src_q, rf_src_d;

  fifo_entry_t       head;
  logic              empty, full, empty_nxt;
  logic [CNT_W-1:0]  squash_cnt;
  logic              push, pop, pipe_slot, aux_write, pipe_stall;

  assign pipe_stall = (state_q == STEAL);
  assign push       = bus.aux_valid & ~full;
  assign pipe_slot  = bus.pipe_wr_en & (bus.pipe_rd != REG_ZERO) & ~pipe_stall;
  assign pop        = ~pipe_slot & ~empty;
  // Squashed or r0 heads are popped but never reach the register file.
  assign aux_write  = pop & ~head.squash & (head.rd != REG_ZERO);

  wb_aux_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_rd    (bus.aux_rd),
    .push_data  (bus.aux_data),
    .pop        (pop),
    .squash_en  (pipe_slot),
    .squash_rd  (bus.pipe_rd),
    .head       (head),
    .empty      (empty),
    .full       (full),
    .empty_nxt  (empty_nxt),
    .squash_cnt (squash_cnt)
  );

  always_comb begin
    state_d    = state_q;
    starve_d   = '0;
    rf_we_d    = pipe_slot | aux_write;
    rf_waddr_d = '0;
    rf_wdata_d = '0;
    rf_src_d   = SRC_PIPE;

    if (pipe_slot) begin
      rf_waddr_d = bus.pipe_rd;
      rf_wdata_d = bus.pipe_data;
    end else if (aux_write) begin
      rf_waddr_d = head.rd;
      rf_wdata_d = head.data;
      rf_src_d   = SRC_AUX;
    end

    case (state_q)
      WAIT: begin
        if (pop) begin
          state_d = empty_nxt ? IDLE : WAIT;
        end else begin
          starve_d = starve_q + 8'd1;
          if (starve_d == 8'(STARVE_LIMIT)) state_d = STEAL;
        end
      end
      // IDLE and STEAL both leave with the counter cleared.
      default: state_d = empty_nxt ? IDLE : WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      rf_src_q   <= SRC_PIPE;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      rf_src_q   <= rf_src_d;
    end
  end

  assign bus.aux_ready  = ~full;
  assign bus.pipe_stall = pipe_stall;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_waddr   = rf_waddr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.rf_src     = rf_src_q;

`ifdef WB_ARB_STATS_EN
  logic [15:0] steals_q, steals_d;
  logic [15:0] squashes_q, squashes_d;
  logic [16:0] squash_sum;

  always_comb begin
    steals_d   = (pipe_stall && steals_q != 16'hFFFF) ? steals_q + 16'd1 : steals_q;
    squash_sum = {1'b0, squashes_q} + 17'(squash_cnt);
    squashes_d = squash_sum[16] ? 16'hFFFF : squash_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      steals_q   <= '0;
      squashes_q <= '0;
    end else begin
      steals_q   <= steals_d;
      squashes_q <= squashes_d;
    end
  end

  assign bus.stat_steals   = steals_q;
  assign bus.stat_squashes = squashes_q;
`else
  logic unused_squash_cnt;
  assign unused_squash_cnt = ^squash_cnt;
`endif

endmodule
